// File: rtl/sub_share_arbiter_if.sv
// rtl/sub_share_arbiter_if.sv - requester/response bundle for the shared subtract arbiter
interface sub_share_arbiter_if #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_diff;
    logic                  rsp_borrow;
    logic                  busy;
    logic [7:0]            op_count;

    // Client side: requesters plus the response consumer
    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_diff, rsp_borrow, busy, op_count
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_diff, rsp_borrow, busy, op_count
    );
endinterface

// File: rtl/sub_share_arbiter.sv
// rtl/sub_share_arbiter.sv - round-robin sharing of one registered a-b datapath
module sub_share_arbiter #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4
) (
    input  logic              clk,
    input  logic              rst,
    sub_share_arbiter_if.slave bus
);
    localparam int IDW = $clog2(NREQ);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   scan_idx;
    logic [IDW-1:0]   grant_idx;
    logic             grant_found;

    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IDW-1:0]   id_q;

    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic [IDW-1:0]   rsp_id_q;
    logic [7:0]       op_count_q;

    logic [NREQ-1:0]  req_ready_c;
    logic             accept;
    logic             consume;

    // Rotating-priority scan: first valid requester at or after rr_ptr, wrapping
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int i = 0; i < NREQ; i++) begin
            scan_idx = IDW'((int'(rr_ptr) + i) % NREQ);
            if (!grant_found && bus.req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    // Operand mux for the winning requester
    always_comb begin
        sel_a = bus.req_a[int'(grant_idx)*WIDTH +: WIDTH];
        sel_b = bus.req_b[int'(grant_idx)*WIDTH +: WIDTH];
    end

    // Sequencer state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Sequencer next state and handshake strobes; accept only ever happens in IDLE
    always_comb begin
        state_nxt   = state;
        req_ready_c = '0;
        accept      = 1'b0;
        consume     = 1'b0;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    accept                 = 1'b1;
                    req_ready_c[grant_idx] = 1'b1;
                    state_nxt              = CALC;
                end
            end
            CALC: begin
                state_nxt = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    consume   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Round-robin pointer moves just past the requester that was accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= (grant_idx == LAST_ID) ? '0 : grant_idx + 1'b1;
        end
    end

    // Capture operands on accept so the requester is free to move on
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q  <= '0;
            b_q  <= '0;
            id_q <= '0;
        end else if (accept) begin
            a_q  <= sel_a;
            b_q  <= sel_b;
            id_q <= grant_idx;
        end
    end

    // Result registers load in CALC and stay put through RESP until consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            diff_q   <= '0;
            borrow_q <= 1'b0;
            rsp_id_q <= '0;
        end else if (state == CALC) begin
            diff_q   <= a_q - b_q;
            borrow_q <= (a_q < b_q);
            rsp_id_q <= id_q;
        end
    end

    // Completed-response counter, free-running modulo 256
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count_q <= '0;
        end else if (consume) begin
            op_count_q <= op_count_q + 8'd1;
        end
    end

    assign bus.req_ready  = req_ready_c;
    assign bus.rsp_valid  = (state == RESP);
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_diff   = diff_q;
    assign bus.rsp_borrow = borrow_q;
    assign bus.busy       = (state != IDLE);
    assign bus.op_count   = op_count_q;
endmodule

// File: tb/tb_sub_share_arbiter.sv
// tb/tb_sub_share_arbiter.sv - directed self-checking bench for sub_share_arbiter
module tb_sub_share_arbiter;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    logic [3:0] ta;
    logic [3:0] tb_b;
    logic [3:0] tdiff;
    logic       tborrow;

    sub_share_arbiter_if #(.WIDTH(4), .NREQ(4)) bus ();

    sub_share_arbiter #(.WIDTH(4), .NREQ(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1 with the block in IDLE; runs one full accept/calc/resp cycle
    task automatic do_op(input logic [3:0] mask, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] exp_ready, input logic [3:0] exp_diff,
                         input logic exp_borrow, input logic [1:0] exp_id, input logic [7:0] exp_count);
        bus.req_valid = mask;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.rsp_ready = 1'b1;
        #1;
        chk("accept_ready", 32'(bus.req_ready), 32'(exp_ready));
        chk("accept_busy", 32'(bus.busy), 32'd0);
        tick;
        bus.req_valid = 4'b0000;
        #1;
        chk("calc_ready", 32'(bus.req_ready), 32'd0);
        chk("calc_busy", 32'(bus.busy), 32'd1);
        chk("calc_valid", 32'(bus.rsp_valid), 32'd0);
        tick;
        chk("resp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("resp_diff", 32'(bus.rsp_diff), 32'(exp_diff));
        chk("resp_borrow", 32'(bus.rsp_borrow), 32'(exp_borrow));
        chk("resp_id", 32'(bus.rsp_id), 32'(exp_id));
        tick;
        chk("done_valid", 32'(bus.rsp_valid), 32'd0);
        chk("done_count", 32'(bus.op_count), 32'(exp_count));
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        rst           = 1'b1;
        bus.req_valid = 4'b0000;
        bus.req_a     = 16'h0000;
        bus.req_b     = 16'h0000;
        bus.rsp_ready = 1'b0;
        tick;
        tick;

        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
        chk("rst_rsp_diff", 32'(bus.rsp_diff), 32'd0);
        chk("rst_rsp_borrow", 32'(bus.rsp_borrow), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_op_count", 32'(bus.op_count), 32'd0);

        rst = 1'b0;
        tick;
        bus.rsp_ready = 1'b1;

        do_op(4'b0001, 16'h0004, 16'h0001, 4'b0001, 4'd3, 1'b0, 2'd0, 8'd1);
        do_op(4'b0100, 16'h0300, 16'h0700, 4'b0100, 4'd12, 1'b1, 2'd2, 8'd2);
        do_op(4'b0010, 16'h0000, 16'h0010, 4'b0010, 4'd15, 1'b1, 2'd1, 8'd3);

        // All requesters active from reset: a_i = i, b_i = 2
        rst           = 1'b1;
        bus.req_valid = 4'b1111;
        bus.req_a     = 16'h3210;
        bus.req_b     = 16'h2222;
        #1;
        chk("rr_rst_count", 32'(bus.op_count), 32'd0);
        tick;
        rst = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("rr_grant", 32'(bus.req_ready), 32'(4'b0001 << (k % 4)));
            tick;
            chk("rr_pulse_width", 32'(bus.req_ready), 32'd0);
            tick;
            chk("rr_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("rr_rsp_id", 32'(k % 4), 32'(bus.rsp_id));
            case (k % 4)
                0: begin tdiff = 4'd14; tborrow = 1'b1; end
                1: begin tdiff = 4'd15; tborrow = 1'b1; end
                2: begin tdiff = 4'd0;  tborrow = 1'b0; end
                default: begin tdiff = 4'd1; tborrow = 1'b0; end
            endcase
            chk("rr_rsp_diff", 32'(bus.rsp_diff), 32'(tdiff));
            chk("rr_rsp_borrow", 32'(bus.rsp_borrow), 32'(tborrow));
            tick;
        end
        bus.req_valid = 4'b0000;
        #1;
        chk("rr_count", 32'(bus.op_count), 32'd5);
        chk("rr_idle_ready", 32'(bus.req_ready), 32'd0);

        // Backpressure: requester 3 (9-2), consumer stalls 5 cycles, requester 0 waits
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b1000;
        bus.req_a     = 16'h9000;
        bus.req_b     = 16'h2000;
        #1;
        chk("bp_grant", 32'(bus.req_ready), 32'b1000);
        tick;
        bus.req_valid = 4'b0001;
        bus.req_a     = 16'h9005;
        bus.req_b     = 16'h2005;
        tick;
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_diff", 32'(bus.rsp_diff), 32'd7);
            chk("bp_id", 32'(bus.rsp_id), 32'd3);
            chk("bp_no_ready", 32'(bus.req_ready), 32'd0);
            tick;
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp_release_valid", 32'(bus.rsp_valid), 32'd1);
        tick;
        chk("bp_after_valid", 32'(bus.rsp_valid), 32'd0);
        chk("bp_after_count", 32'(bus.op_count), 32'd6);
        chk("bp_next_grant", 32'(bus.req_ready), 32'b0001);
        bus.req_valid = 4'b0000;
        #1;
        chk("skip_ready", 32'(bus.req_ready), 32'd0);
        tick;

        // Reset during CALC after accepting 7-3 from requester 0
        bus.req_valid = 4'b0001;
        bus.req_a     = 16'h0007;
        bus.req_b     = 16'h0003;
        #1;
        chk("mid_grant", 32'(bus.req_ready), 32'b0001);
        tick;
        bus.req_valid = 4'b0000;
        #1;
        chk("mid_calc_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_busy", 32'(bus.busy), 32'd0);
        chk("mid_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mid_ready", 32'(bus.req_ready), 32'd0);
        chk("mid_count", 32'(bus.op_count), 32'd0);
        chk("mid_diff", 32'(bus.rsp_diff), 32'd0);
        chk("mid_id", 32'(bus.rsp_id), 32'd0);
        tick;
        tick;
        chk("mid_hold_valid", 32'(bus.rsp_valid), 32'd0);
        rst = 1'b0;
        do_op(4'b1111, 16'h0007, 16'h0003, 4'b0001, 4'd4, 1'b0, 2'd0, 8'd1);

        // Only requester 3 requests; 255 more operations take op_count 1 -> 0
        for (int k = 0; k < 255; k++) begin
            ta      = 4'(k);
            tb_b    = 4'(k * 7);
            tdiff   = ta - tb_b;
            tborrow = (ta < tb_b);
            do_op(4'b1000, {ta, 12'h000}, {tb_b, 12'h000}, 4'b1000, tdiff, tborrow, 2'd3, 8'(k + 2));
        end
        chk("wrap_count", 32'(bus.op_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sub_share_arbiter.md
Name: sub_share_arbiter

Overview:
Shares one WIDTH-bit subtract datapath (diff = a - b, modulo 2^WIDTH) among NREQ requesters. A round-robin arbiter grants one requester at a time and latches its operands. A three-state sequencer then computes the registered result and holds it on a valid/ready response port until it is consumed. The block sits between the requester clients and the arithmetic unit, which is implemented internally.

Parameters:
WIDTH, 4, operand and result width in bits
NREQ, 4, number of requesters (2..8)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
req_valid  input  NREQ  per-requester request valid; bit i belongs to requester i
req_a  input  NREQ*WIDTH  minuend operands; requester i occupies bits [i*WIDTH +: WIDTH]
req_b  input  NREQ*WIDTH  subtrahend operands, packed the same way as req_a
req_ready  output  NREQ  one-hot accept pulse for the granted requester
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumer ready
rsp_id  output  $clog2(NREQ)  index of the requester that owns the response
rsp_diff  output  WIDTH  registered a - b, modulo 2^WIDTH
rsp_borrow  output  1  1 when a < b (unsigned)
busy  output  1  high whenever the state is not IDLE
op_count  output  8  count of completed responses, wraps 255 -> 0

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, rr_ptr=0.
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_diff=0, rsp_borrow=0, busy=0, op_count=0.
  - Operand latches cleared to 0.
- Reset asserted mid-operation aborts the operation: the pending response is discarded, no req_ready pulse is issued, and op_count is not incremented.
- States: IDLE, CALC, RESP.
- IDLE:
  - If any req_valid bit is set, the grant g is the first set bit scanning from rr_ptr upward, wrapping at NREQ-1 -> 0.
  - req_ready[g]=1 combinationally in that same cycle; this is the accept handshake.
  - Latch a_q=req_a[g], b_q=req_b[g], id_q=g; next state CALC.
  - rr_ptr <= (g+1) mod NREQ on accept.
  - If no req_valid bit is set, stay in IDLE with req_ready=0.
- CALC:
  - Register rsp_diff <= a_q - b_q (low WIDTH bits), rsp_borrow <= (a_q < b_q), rsp_id <= id_q.
  - Next state RESP.
- RESP:
  - rsp_valid=1. rsp_diff, rsp_borrow and rsp_id are held stable until consumed.
  - On rsp_valid && rsp_ready: op_count increments, next state IDLE, and rsp_valid falls the following cycle.
- req_ready is 0 in every state other than IDLE. Requesters must hold req_valid and operands stable until they see req_ready.
- Latency: accept at cycle 0, rsp_valid=1 at cycle 2. Minimum spacing between accepts is 3 cycles.
- rsp_ready asserted early (before RESP) has no effect. rsp_ready held low stalls the block indefinitely in RESP.
- A requester that drops req_valid before being granted is simply skipped.
- Fairness: a requester that holds req_valid continuously is granted within NREQ accepts.
- a == b gives diff=0, borrow=0. Wrap-around example: 0 - 1 gives diff=2^WIDTH-1, borrow=1.
- busy=1 in CALC and RESP.

Test Plan:
- Single request, requester 0, a=4, b=1 -> req_ready=0001 at cycle 0; rsp_valid at cycle 2 with diff=3, borrow=0, id=0; op_count=1.
- Requester 2, a=3, b=7 -> diff=12, borrow=1, id=2. Requester 1, a=0, b=1 -> diff=15, borrow=1.
- All four req_valid held high from reset, rsp_ready=1 -> grants in order 0,1,2,3,0; each req_ready pulse is one cycle wide and one-hot; responses arrive every 3 cycles.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, diff and id are held; no req_ready pulses; the block proceeds on the cycle rsp_ready=1.
- Reset mid-CALC after an accept of a=7, b=3 -> all outputs return to reset values; no response is produced; op_count=0; the next accept after release grants requester 0 first (rr_ptr=0).
- Run 256 completed operations -> op_count wraps to 0. With only requester 3 requesting, rr_ptr wraps 3 -> 0 and requester 3 is re-granted on each operation.
